// File: rtl/mem_access_unit.sv
// Load/store stage between the CPU ALU and a word-wide data RAM.
// Handles lane steering, load extension, fault detection and a req/ack timeout.
module mem_access_unit #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ack
);

  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, DONE = 2'b10} state_t;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lat_lo;
  logic [1:0]       lat_size;
  logic             lat_uns;
  logic             lat_write;
  logic             request;
  logic             fault;

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] lo,
                                              input logic uns, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign request = mem_read | mem_write;
  assign fault   = (mem_read & mem_write) | (mem_size == 2'b11) |
                   ((mem_size == 2'b01) & addr[0]) |
                   ((mem_size == 2'b10) & (addr[1:0] != 2'b00));
  // stall is combinational so the CPU freezes in the same cycle the request appears
  assign stall   = reset & ((state == REQ) | ((state == IDLE) & request));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_lo    <= 2'b00;
      lat_size  <= 2'b00;
      lat_uns   <= 1'b0;
      lat_write <= 1'b0;
      rdata     <= 32'h0000_0000;
      done      <= 1'b0;
      err       <= 1'b0;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_be    <= 4'b0000;
      ram_wdata <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (request && fault) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (request) begin
            lat_lo    <= addr[1:0];
            lat_size  <= mem_size;
            lat_uns   <= mem_unsigned;
            lat_write <= mem_write;
            ram_req   <= 1'b1;
            ram_we    <= mem_write;
            ram_addr  <= addr[ADDR_W-1:2];
            ram_be    <= byte_enables(mem_size, addr[1:0]);
            ram_wdata <= replicate(mem_size, wdata);
            cnt       <= '0;
            state     <= REQ;
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (ram_ack) begin
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
            ram_be  <= 4'b0000;
            if (!lat_write) begin
              rdata <= load_extend(lat_size, lat_lo, lat_uns, ram_rdata);
            end
            err   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
            ram_be  <= 4'b0000;
            if (!lat_write) begin
              rdata <= 32'h0000_0000;
            end
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          ram_req <= 1'b0;
          ram_we  <= 1'b0;
          ram_be  <= 4'b0000;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
